// File: rtl/rf_sequencer_pkg.sv
// Shared register-file sequencer definitions: register count, FSM states, zero-register index
// and a population-count helper.
package rf_sequencer_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_ZERO = 0;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int unsigned popcount32(input logic [NUM_REGS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Load scoreboard: one pending bit per register, combinational hazard, registered pend_cnt.
// Set at load-accept edge, clear at writeback edge; hazard uses registered bits, so the stall ends one cycle after writeback.
module rf_scoreboard
    import rf_sequencer_pkg::*;
#(
    parameter int AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    input  logic              id_valid_i,
    input  logic [AWIDTH-1:0] id_rs1_i,
    input  logic [AWIDTH-1:0] id_rs2_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic [AWIDTH-1:0] id_rd_i,
    input  logic              id_load_i,
    input  logic              wb_we_i,
    input  logic [AWIDTH-1:0] wb_rd_i,
    output logic              haz_o,
    output logic [AWIDTH:0]   pend_cnt_o
);

    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [AWIDTH:0]     pend_cnt_q, pend_cnt_d;
    logic                set_en;

    assign haz_o = id_valid_i & ((id_use_rs1_i & pend_q[id_rs1_i]) |
                                 (id_use_rs2_i & pend_q[id_rs2_i]));

    // A load is only accepted when decode is not held, i.e. out of INIT and free of hazards.
    assign set_en = id_valid_i & id_load_i & run_i & ~haz_o &
                    (id_rd_i != AWIDTH'(REG_ZERO));

    always_comb begin
        pend_d = pend_q;
        if (wb_we_i) begin
            pend_d[wb_rd_i] = 1'b0;
        end
        if (set_en) begin
            pend_d[id_rd_i] = 1'b1;
        end
        pend_d[REG_ZERO] = 1'b0;
    end

    assign pend_cnt_d = (AWIDTH+1)'(popcount32(pend_d));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt_o = pend_cnt_q;

endmodule

// File: rtl/rf_sequencer.sv
// Register-file write-port owner: zero sweep after reset, then writeback-over-debug arbitration and load stall.
// Write outputs are combinational; debug is held off while writeback writes a non-zero register.
module rf_sequencer
    import rf_sequencer_pkg::*;
#(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [AWIDTH-1:0] id_rs1,
    input  logic [AWIDTH-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [AWIDTH-1:0] id_rd,
    input  logic              id_load,
    input  logic              wb_we,
    input  logic [AWIDTH-1:0] wb_rd,
    input  logic [DWIDTH-1:0] wb_data,
    input  logic              dbg_req,
    input  logic [AWIDTH-1:0] dbg_addr,
    input  logic [DWIDTH-1:0] dbg_data,
    output logic              dbg_gnt,
    output logic              rf_we,
    output logic [AWIDTH-1:0] rf_wa,
    output logic [DWIDTH-1:0] rf_wd,
    output logic              stall_id,
    output logic              init_done,
    output logic [AWIDTH:0]   pend_cnt
);

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    logic              init_done_q, init_done_d;
    logic              run;
    logic              haz;
    logic              wb_win;
    logic              dbg_win;

    assign run = (state_q == ST_RUN);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + AWIDTH'(1);
            if (cnt_q == AWIDTH'(NUM_REGS - 1)) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // Writeback to x0 does not claim the port, so a waiting debug request may use that cycle.
    assign wb_win  = run & wb_we & (wb_rd != AWIDTH'(REG_ZERO));
    assign dbg_win = run & ~wb_win & dbg_req;

    always_comb begin
        rf_we   = 1'b0;
        rf_wa   = '0;
        rf_wd   = '0;
        dbg_gnt = 1'b0;
        if (!run) begin
            rf_we = 1'b1;
            rf_wa = cnt_q;
        end else if (wb_win) begin
            rf_we = 1'b1;
            rf_wa = wb_rd;
            rf_wd = wb_data;
        end else if (dbg_win) begin
            dbg_gnt = 1'b1;
            rf_we   = (dbg_addr != AWIDTH'(REG_ZERO));
            rf_wa   = dbg_addr;
            rf_wd   = dbg_data;
        end
    end

    rf_scoreboard #(
        .AWIDTH(AWIDTH)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .run_i        (run),
        .id_valid_i   (id_valid),
        .id_rs1_i     (id_rs1),
        .id_rs2_i     (id_rs2),
        .id_use_rs1_i (id_use_rs1),
        .id_use_rs2_i (id_use_rs2),
        .id_rd_i      (id_rd),
        .id_load_i    (id_load),
        .wb_we_i      (wb_we),
        .wb_rd_i      (wb_rd),
        .haz_o        (haz),
        .pend_cnt_o   (pend_cnt)
    );

    assign stall_id  = ~run | haz;
    assign init_done = init_done_q;

endmodule
